// File: rtl/spi_flash_pkg.sv
// Purpose: shared opcodes, FSM state encoding and JEDEC byte selection for the SPI flash responder.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package spi_flash_pkg;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_RDID = 8'h9F;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_WRDI = 8'h04;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA_OUT,
        ID_OUT,
        SR_OUT,
        WAIT_CS
    } state_t;

    // Byte idx of the 3-byte JEDEC identifier, manufacturer byte first.
    function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
        case (idx)
            2'd0:    return id[23:16];
            2'd1:    return id[15:8];
            default: return id[7:0];
        endcase
    endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Purpose: brings the asynchronous SPI pins into the clk domain and flags sclk edges.
// Latency: 2 clk from pin to di_s/cs_active; edge strobes valid in the cycle after the 2nd flop updates.
// Backpressure: none; pins are sampled every clk.
module spi_slave_sync (
    input  logic clk,
    input  logic rst,
    input  logic flash_cs_n,
    input  logic flash_clk,
    input  logic flash_di,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_active,
    output logic di_s
);

    // sclk keeps a third stage so edges are detected on already-synchronised values.
    logic [2:0] sclk_q, sclk_d;
    logic [1:0] cs_q, cs_d;
    logic [1:0] di_q, di_d;

    // Shift each pin into its synchroniser chain.
    always_comb begin
        sclk_d = {sclk_q[1:0], flash_clk};
        cs_d   = {cs_q[0], flash_cs_n};
        di_d   = {di_q[0], flash_di};
    end

    // Synchroniser registers reset to the bus idle levels (cs deasserted, sclk low).
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= 3'b000;
            cs_q   <= 2'b11;
            di_q   <= 2'b00;
        end else begin
            sclk_q <= sclk_d;
            cs_q   <= cs_d;
            di_q   <= di_d;
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_active = ~cs_q[1];
    assign di_s      = di_q[1];

endmodule

// File: rtl/spi_flash_responder.sv
// Purpose: SPI-flash target (mode 0, MSB first) serving READ, RDID, RDSR, WREN and WRDI from a byte memory port.
// Latency: response MSB on the sclk fall after the 8th rise of the previous byte; mem_rd 1 clk after the detected rise.
// Backpressure: none; master must keep flash_clk <= clk/4, memory must answer 1 clk after mem_rd.
module spi_flash_responder #(
    parameter logic [23:0] JEDEC_ID  = 24'hEF4015,
    parameter int          ADDR_BITS = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flash_cs_n,
    input  logic                 flash_clk,
    input  logic                 flash_di,
    output logic                 flash_do,
    output logic                 flash_do_oe,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_rd,
    input  logic [7:0]           mem_data,
    output logic                 busy
);
    import spi_flash_pkg::*;

    logic sclk_rise, sclk_fall, cs_active, di_s;

    spi_slave_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .flash_cs_n (flash_cs_n),
        .flash_clk  (flash_clk),
        .flash_di   (flash_di),
        .sclk_rise  (sclk_rise),
        .sclk_fall  (sclk_fall),
        .cs_active  (cs_active),
        .di_s       (di_s)
    );

    state_t                state_q, state_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [22:0]           shift_in_q, shift_in_d;
    logic [7:0]            shift_out_q, shift_out_d;
    logic [1:0]            id_idx_q, id_idx_d;
    logic                  do_q, do_d;
    logic                  oe_q, oe_d;
    logic                  mem_rd_q, mem_rd_d;
    logic                  rd_dly_q, rd_dly_d;
    logic                  wel_q, wel_d;
    logic                  wel_set_q, wel_set_d;
    logic                  wel_clr_q, wel_clr_d;
    logic                  cs_prev_q, cs_prev_d;
    logic [ADDR_BITS-1:0]  mem_addr_q, mem_addr_d;

    logic [7:0]  out_byte;
    logic [7:0]  cmd_byte;
    logic [23:0] addr_word;

    // Next-state, shift registers, memory strobes and pin outputs.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_in_d  = shift_in_q;
        shift_out_d = shift_out_q;
        id_idx_d    = id_idx_q;
        do_d        = do_q;
        oe_d        = oe_q;
        mem_rd_d    = 1'b0;
        rd_dly_d    = mem_rd_q;
        wel_d       = wel_q;
        wel_set_d   = wel_set_q;
        wel_clr_d   = wel_clr_q;
        cs_prev_d   = cs_active;
        mem_addr_d  = mem_addr_q;

        // At flash_clk = clk/4 the fall after a fetch lands in the same clk as mem_data,
        // so the memory byte is forwarded straight to the output shifter.
        out_byte  = rd_dly_q ? mem_data : shift_out_q;
        cmd_byte  = {shift_in_q[6:0], di_s};
        addr_word = {shift_in_q, di_s};

        if (rd_dly_q) begin
            shift_out_d = mem_data;
        end

        if (!cs_active) begin
            // Deselect aborts everything, including partial bytes; WEL changes commit here.
            state_d   = IDLE;
            bit_cnt_d = 5'd0;
            oe_d      = 1'b0;
            do_d      = 1'b1;
            if (wel_set_q) begin
                wel_d = 1'b1;
            end else if (wel_clr_q) begin
                wel_d = 1'b0;
            end
            wel_set_d = 1'b0;
            wel_clr_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!cs_prev_q) begin
                        state_d   = CMD;
                        bit_cnt_d = 5'd0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        shift_in_d = addr_word[22:0];
                        bit_cnt_d  = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = 5'd0;
                            state_d   = WAIT_CS;
                            case (cmd_byte)
                                OP_READ: state_d = ADDR;
                                OP_RDID: begin
                                    state_d     = ID_OUT;
                                    shift_out_d = id_byte(JEDEC_ID, 2'd0);
                                    id_idx_d    = 2'd1;
                                    oe_d        = 1'b1;
                                end
                                OP_RDSR: begin
                                    state_d     = SR_OUT;
                                    shift_out_d = {6'b0, wel_q, 1'b0};
                                    oe_d        = 1'b1;
                                end
                                OP_WREN: begin
                                    wel_set_d = 1'b1;
                                    wel_clr_d = 1'b0;
                                end
                                OP_WRDI: begin
                                    wel_set_d = 1'b0;
                                    wel_clr_d = 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ADDR: begin
                    if (sclk_rise) begin
                        shift_in_d = addr_word[22:0];
                        bit_cnt_d  = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d  = 5'd0;
                            mem_addr_d = addr_word[ADDR_BITS-1:0];
                            mem_rd_d   = 1'b1;
                            oe_d       = 1'b1;
                            state_d    = DATA_OUT;
                        end
                    end
                end
                DATA_OUT, ID_OUT, SR_OUT: begin
                    if (sclk_fall) begin
                        do_d        = out_byte[7];
                        shift_out_d = {out_byte[6:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            // Byte boundary: fetch/reload the next byte before the coming fall.
                            bit_cnt_d = 5'd0;
                            if (state_q == DATA_OUT) begin
                                mem_addr_d = mem_addr_q + ADDR_BITS'(1);
                                mem_rd_d   = 1'b1;
                            end else if (state_q == ID_OUT) begin
                                shift_out_d = id_byte(JEDEC_ID, id_idx_q);
                                id_idx_d    = (id_idx_q == 2'd2) ? 2'd0 : id_idx_q + 2'd1;
                            end else begin
                                shift_out_d = {6'b0, wel_q, 1'b0};
                            end
                        end
                    end
                end
                default: begin
                    oe_d = 1'b0;
                    do_d = 1'b1;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 5'd0;
            shift_in_q  <= '0;
            shift_out_q <= 8'h00;
            id_idx_q    <= 2'd0;
            do_q        <= 1'b1;
            oe_q        <= 1'b0;
            mem_rd_q    <= 1'b0;
            rd_dly_q    <= 1'b0;
            wel_q       <= 1'b0;
            wel_set_q   <= 1'b0;
            wel_clr_q   <= 1'b0;
            cs_prev_q   <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            id_idx_q    <= id_idx_d;
            do_q        <= do_d;
            oe_q        <= oe_d;
            mem_rd_q    <= mem_rd_d;
            rd_dly_q    <= rd_dly_d;
            wel_q       <= wel_d;
            wel_set_q   <= wel_set_d;
            wel_clr_q   <= wel_clr_d;
            cs_prev_q   <= cs_prev_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    assign flash_do    = do_q;
    assign flash_do_oe = oe_q;
    assign mem_addr    = mem_addr_q;
    assign mem_rd      = mem_rd_q;
    assign busy        = (state_q != IDLE);

endmodule
